// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and limits for the bit serializer
package ser_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_MAX_WIDTH = 32;

endpackage

// File: rtl/ser_hold_buf.sv
// rtl/ser_hold_buf.sv - one-entry holding buffer in front of the shifter
// word_ready is a register tracking the next value of ~hold_full so it never depends on inputs combinationally.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  input  logic             pop_i,
  output logic             word_ready_o,
  output logic [WIDTH-1:0] hold_word_o,
  output logic             hold_full_o,
  output logic             hold_full_next_o
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             word_ready_q;
  logic             push;

  // push requires an empty hold and pop requires a full one, so they never coincide
  assign push        = word_valid & word_ready_q;
  assign hold_full_d = push | (hold_full_q & ~pop_i);
  assign hold_d      = push ? word_in : hold_q;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      word_ready_q <= 1'b1;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      word_ready_q <= ~hold_full_d;
    end
  end

  assign word_ready_o     = word_ready_q;
  assign hold_word_o      = hold_q;
  assign hold_full_o      = hold_full_q;
  assign hold_full_next_o = hold_full_d;

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial source with one-word hold buffer
// Every output is computed from next-state values and registered, so ser_out changes only on clk or R.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_last_q, frame_last_d;
  logic             busy_q, busy_d;

  logic             load;
  logic [WIDTH-1:0] hold_word;
  logic             hold_full;
  logic             hold_full_next;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk              (clk),
    .R                (R),
    .word_in          (word_in),
    .word_valid       (word_valid),
    .pop_i            (load),
    .word_ready_o     (word_ready),
    .hold_word_o      (hold_word),
    .hold_full_o      (hold_full),
    .hold_full_next_o (hold_full_next)
  );

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load    = 1'b0;
    unique case (state_q)
      SER_IDLE: load = hold_full;
      SER_SHIFT: begin
        if (cnt_q != CNT_MAX) begin
          shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_d = SER_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = SER_IDLE;
    endcase
    // a pending word enters the shifter directly after the last bit, keeping the stream gapless
    if (load) begin
      shift_d = hold_word;
      cnt_d   = '0;
      state_d = SER_SHIFT;
    end
  end

  always_comb begin
    ser_valid_d  = (state_d == SER_SHIFT);
    ser_out_d    = ser_valid_d ? head_bit(shift_d) : IDLE_BIT;
    frame_last_d = ser_valid_d && (cnt_d == CNT_MAX);
    busy_d       = hold_full_next | ser_valid_d;
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q      <= SER_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_last_q <= frame_last_d;
      busy_q       <= busy_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_last = frame_last_q;
  assign busy       = busy_q;

endmodule
